// File: rtl/fde_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fde_pkg
//  Description : Shared encodings for the fetch/decode/execute datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package fde_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SHL   = 3'b101;
    localparam logic [2:0] ALU_SHR   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Immediate deliberately overlaps the reg2 address field.
    localparam int OPCODE_MSB  = 23;
    localparam int OPCODE_LSB  = 20;
    localparam int REGDEST_MSB = 19;
    localparam int REGDEST_LSB = 16;
    localparam int REG1_MSB    = 15;
    localparam int REG1_LSB    = 12;
    localparam int REG2_MSB    = 11;
    localparam int REG2_LSB    = 8;
    localparam int IMM_MSB     = 11;
    localparam int IMM_LSB     = 0;
    localparam int IMM_BITS    = IMM_MSB - IMM_LSB + 1;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } aluFlags_t;

endpackage : fde_pkg
`default_nettype wire

// File: rtl/fde_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : fde_datapath_if
//  Description : Stage-boundary signal bundle of the fetch/decode/execute path.
//  Revision    : 1.0  initial release
// ============================================================================
interface fde_datapath_if #(
    parameter int WIDTH            = 16,
    parameter int ADDRESSWIDTH     = 4,
    parameter int OPCODEWIDTH      = 4,
    parameter int INSTRUCTIONWIDTH = 24
);
    // Fetch
    logic [WIDTH-1:0]            newPC;
    logic                        takeBranch;
    logic                        fetchEnable;
    logic [WIDTH-1:0]            pcF;
    // Decode
    logic [INSTRUCTIONWIDTH-1:0] instructionD;
    logic [WIDTH-1:0]            pcD;
    logic                        pcAsR1;
    logic                        regWriteEnable;
    logic [ADDRESSWIDTH-1:0]     writeAddress;
    logic [WIDTH-1:0]            writeData;
    logic [WIDTH-1:0]            reg1ContentD;
    logic [WIDTH-1:0]            reg2ContentD;
    logic [WIDTH-1:0]            immediateD;
    logic [ADDRESSWIDTH-1:0]     regDestD;
    logic [ADDRESSWIDTH-1:0]     reg1AddrD;
    logic [ADDRESSWIDTH-1:0]     reg2AddrD;
    logic [OPCODEWIDTH-1:0]      opcodeD;
    // Execute
    logic [WIDTH-1:0]            reg1ContentE;
    logic [WIDTH-1:0]            reg2ContentE;
    logic [WIDTH-1:0]            immediateE;
    logic [WIDTH-1:0]            forwardM;
    logic [WIDTH-1:0]            forwardWB;
    logic [2:0]                  aluControl;
    logic                        data2Select;
    logic [1:0]                  fwd1Select;
    logic [1:0]                  fwd2Select;
    logic [WIDTH-1:0]            aluOut;
    logic                        N;
    logic                        Z;
    logic                        V;
    logic                        C;

    modport master (
        output newPC, takeBranch, fetchEnable,
        output instructionD, pcD, pcAsR1, regWriteEnable, writeAddress, writeData,
        output reg1ContentE, reg2ContentE, immediateE, forwardM, forwardWB,
        output aluControl, data2Select, fwd1Select, fwd2Select,
        input  pcF,
        input  reg1ContentD, reg2ContentD, immediateD, regDestD, reg1AddrD, reg2AddrD, opcodeD,
        input  aluOut, N, Z, V, C
    );

    modport slave (
        input  newPC, takeBranch, fetchEnable,
        input  instructionD, pcD, pcAsR1, regWriteEnable, writeAddress, writeData,
        input  reg1ContentE, reg2ContentE, immediateE, forwardM, forwardWB,
        input  aluControl, data2Select, fwd1Select, fwd2Select,
        output pcF,
        output reg1ContentD, reg2ContentD, immediateD, regDestD, reg1AddrD, reg2AddrD, opcodeD,
        output aluOut, N, Z, V, C
    );

endinterface : fde_datapath_if
`default_nettype wire

// File: rtl/fde_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : fde_regfile
//  Description : Two-read one-write register file with same-cycle write-through.
//  Revision    : 1.0  initial release
// ============================================================================
module fde_regfile #(
    parameter int WIDTH        = 16,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_writeEnable,
    input  wire logic [ADDRESSWIDTH-1:0] i_writeAddress,
    input  wire logic [WIDTH-1:0]        i_writeData,
    input  wire logic [ADDRESSWIDTH-1:0] i_readAddr1,
    input  wire logic [ADDRESSWIDTH-1:0] i_readAddr2,
    output logic      [WIDTH-1:0]        o_readData1,
    output logic      [WIDTH-1:0]        o_readData2
);

    logic [WIDTH-1:0] r_regs [REGNUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGNUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_writeEnable) begin
            r_regs[i_writeAddress] <= i_writeData;
        end
    end

    // Bypass lets a WB write be read by decode in the same cycle.
    assign o_readData1 = (i_writeEnable && (i_writeAddress == i_readAddr1)) ?
                         i_writeData : r_regs[i_readAddr1];
    assign o_readData2 = (i_writeEnable && (i_writeAddress == i_readAddr2)) ?
                         i_writeData : r_regs[i_readAddr2];

endmodule : fde_regfile
`default_nettype wire

// File: rtl/fde_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : fde_datapath
//  Description : Fetch PC, decode field split with register file, execute ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module fde_datapath
    import fde_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int REGNUM           = 16,
    parameter int ADDRESSWIDTH     = 4,
    parameter int OPCODEWIDTH      = 4,
    parameter int INSTRUCTIONWIDTH = 24
) (
    input wire logic      clock,
    input wire logic      reset,
    fde_datapath_if.slave bus
);

    logic [WIDTH-1:0]        r_pc;
    logic [ADDRESSWIDTH-1:0] w_reg1Addr;
    logic [ADDRESSWIDTH-1:0] w_reg2Addr;
    logic [WIDTH-1:0]        w_reg1Data;
    logic [WIDTH-1:0]        w_reg2Data;
    logic [WIDTH-1:0]        w_opA;
    logic [WIDTH-1:0]        w_fwdB;
    logic [WIDTH-1:0]        w_opB;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH:0]          w_diff;
    logic [WIDTH-1:0]        w_result;
    aluFlags_t               w_flags;

    // ---------------- Fetch ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= '0;
        end else if (bus.takeBranch) begin
            r_pc <= bus.newPC;
        end else if (bus.fetchEnable) begin
            r_pc <= r_pc + WIDTH'(1);
        end
    end

    assign bus.pcF = r_pc;

    // ---------------- Decode ----------------
    assign bus.opcodeD    = bus.instructionD[OPCODE_MSB:OPCODE_LSB];
    assign bus.regDestD   = bus.instructionD[REGDEST_MSB:REGDEST_LSB];
    assign w_reg1Addr     = bus.instructionD[REG1_MSB:REG1_LSB];
    assign w_reg2Addr     = bus.instructionD[REG2_MSB:REG2_LSB];
    assign bus.reg1AddrD  = w_reg1Addr;
    assign bus.reg2AddrD  = w_reg2Addr;
    assign bus.immediateD = {{(WIDTH-IMM_BITS){bus.instructionD[IMM_MSB]}},
                             bus.instructionD[IMM_MSB:IMM_LSB]};

    fde_regfile #(
        .WIDTH        (WIDTH),
        .REGNUM       (REGNUM),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_regfile (
        .clk            (clock),
        .rst            (reset),
        .i_writeEnable  (bus.regWriteEnable),
        .i_writeAddress (bus.writeAddress),
        .i_writeData    (bus.writeData),
        .i_readAddr1    (w_reg1Addr),
        .i_readAddr2    (w_reg2Addr),
        .o_readData1    (w_reg1Data),
        .o_readData2    (w_reg2Data)
    );

    assign bus.reg1ContentD = bus.pcAsR1 ? bus.pcD : w_reg1Data;
    assign bus.reg2ContentD = w_reg2Data;

    // ---------------- Execute ----------------
    always_comb begin
        w_opA = bus.reg1ContentE;
        case (bus.fwd1Select)
            FWD_WB:  w_opA = bus.forwardWB;
            FWD_M:   w_opA = bus.forwardM;
            default: w_opA = bus.reg1ContentE;
        endcase

        w_fwdB = bus.reg2ContentE;
        case (bus.fwd2Select)
            FWD_WB:  w_fwdB = bus.forwardWB;
            FWD_M:   w_fwdB = bus.forwardM;
            default: w_fwdB = bus.reg2ContentE;
        endcase
    end

    assign w_opB  = bus.data2Select ? bus.immediateE : w_fwdB;
    assign w_sum  = {1'b0, w_opA} + {1'b0, w_opB};
    // Top bit of the extended difference is the unsigned borrow.
    assign w_diff = {1'b0, w_opA} - {1'b0, w_opB};

    always_comb begin
        w_result  = '0;
        w_flags.c = 1'b0;
        w_flags.v = 1'b0;
        case (bus.aluControl)
            ALU_ADD: begin
                w_result  = w_sum[WIDTH-1:0];
                w_flags.c = w_sum[WIDTH];
                w_flags.v = (w_opA[WIDTH-1] == w_opB[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != w_opA[WIDTH-1]);
            end
            ALU_SUB: begin
                w_result  = w_diff[WIDTH-1:0];
                w_flags.c = ~w_diff[WIDTH];
                w_flags.v = (w_opA[WIDTH-1] != w_opB[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != w_opA[WIDTH-1]);
            end
            ALU_AND:   w_result = w_opA & w_opB;
            ALU_OR:    w_result = w_opA | w_opB;
            ALU_XOR:   w_result = w_opA ^ w_opB;
            ALU_SHL:   w_result = w_opA << w_opB[3:0];
            ALU_SHR:   w_result = w_opA >> w_opB[3:0];
            ALU_PASSB: w_result = w_opB;
            default:   w_result = '0;
        endcase
        w_flags.n = w_result[WIDTH-1];
        w_flags.z = (w_result == '0);
    end

    assign bus.aluOut = w_result;
    assign bus.N      = w_flags.n;
    assign bus.Z      = w_flags.z;
    assign bus.V      = w_flags.v;
    assign bus.C      = w_flags.c;

endmodule : fde_datapath
`default_nettype wire

// File: tb/tb_fde_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fde_datapath
//  Description : Scoreboard bench for the fetch/decode/execute datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fde_datapath;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        d2;
        logic [15:0] imm;
        logic [15:0] out;
        logic [3:0]  nzvc;
    } aluCase_t;

    typedef struct {
        logic [15:0] out;
        logic [3:0]  nzvc;
    } aluExp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] expQ [$];
    aluExp_t     aluQ [$];

    fde_datapath_if bus ();

    fde_datapath dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        logic [15:0] e;
        @(negedge clock);
        reset = 1'b1;
        bus.fetchEnable = 1'b1;
        bus.regWriteEnable = 1'b1;
        bus.writeAddress = 4'd5;
        bus.writeData = 16'hFFFF;
        @(negedge clock);
        reset = 1'b0;
        bus.fetchEnable = 1'b0;
        bus.regWriteEnable = 1'b0;
        bus.instructionD = 24'h005000;
        expQ.push_back(16'h0000);
        #1;
        e = expQ.pop_front(); checks++;
        if (bus.pcF !== e) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", bus.pcF, e);
        end
        expQ.push_back(16'h0000);
        e = expQ.pop_front(); checks++;
        if (bus.reg1ContentD !== e) begin
            errors++; $display("FAIL reset_over_write R5: got %h expected %h", bus.reg1ContentD, e);
        end
    endtask

    task automatic test_pc();
        logic [15:0] e;
        for (int i = 1; i <= 3; i++) begin
            bus.fetchEnable = 1'b1;
            expQ.push_back(16'(i));
            @(negedge clock);
            e = expQ.pop_front(); checks++;
            if (bus.pcF !== e) begin
                errors++; $display("FAIL pc_increment[%0d]: got %h expected %h", i, bus.pcF, e);
            end
        end
        bus.fetchEnable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back(16'h0003);
            @(negedge clock);
            e = expQ.pop_front(); checks++;
            if (bus.pcF !== e) begin
                errors++; $display("FAIL pc_hold[%0d]: got %h expected %h", i, bus.pcF, e);
            end
        end
        bus.takeBranch = 1'b1;
        bus.newPC = 16'h0040;
        expQ.push_back(16'h0040);
        @(negedge clock);
        bus.takeBranch = 1'b0;
        e = expQ.pop_front(); checks++;
        if (bus.pcF !== e) begin
            errors++; $display("FAIL pc_branch_over_stall: got %h expected %h", bus.pcF, e);
        end
        bus.takeBranch = 1'b1;
        bus.fetchEnable = 1'b1;
        bus.newPC = 16'hFFFF;
        expQ.push_back(16'hFFFF);
        @(negedge clock);
        bus.takeBranch = 1'b0;
        e = expQ.pop_front(); checks++;
        if (bus.pcF !== e) begin
            errors++; $display("FAIL pc_branch_priority: got %h expected %h", bus.pcF, e);
        end
        expQ.push_back(16'h0000);
        @(negedge clock);
        bus.fetchEnable = 1'b0;
        e = expQ.pop_front(); checks++;
        if (bus.pcF !== e) begin
            errors++; $display("FAIL pc_wrap: got %h expected %h", bus.pcF, e);
        end
    endtask

    task automatic test_regfile();
        logic [15:0] e;
        bus.regWriteEnable = 1'b1;
        bus.writeAddress = 4'd5;
        bus.writeData = 16'h1234;
        @(negedge clock);
        bus.regWriteEnable = 1'b0;
        bus.instructionD = 24'h125300;
        expQ.push_back(16'h1234);
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0002);
        expQ.push_back(16'h0300);
        expQ.push_back(16'h0005);
        expQ.push_back(16'h0003);
        #1;
        e = expQ.pop_front(); checks++;
        if (bus.reg1ContentD !== e) begin
            errors++; $display("FAIL rf_read_r5: got %h expected %h", bus.reg1ContentD, e);
        end
        e = expQ.pop_front(); checks++;
        if ({12'h000, bus.opcodeD} !== e) begin
            errors++; $display("FAIL dec_opcode: got %h expected %h", bus.opcodeD, e);
        end
        e = expQ.pop_front(); checks++;
        if ({12'h000, bus.regDestD} !== e) begin
            errors++; $display("FAIL dec_regdest: got %h expected %h", bus.regDestD, e);
        end
        e = expQ.pop_front(); checks++;
        if (bus.immediateD !== e) begin
            errors++; $display("FAIL dec_immediate: got %h expected %h", bus.immediateD, e);
        end
        e = expQ.pop_front(); checks++;
        if ({12'h000, bus.reg1AddrD} !== e) begin
            errors++; $display("FAIL dec_reg1addr: got %h expected %h", bus.reg1AddrD, e);
        end
        e = expQ.pop_front(); checks++;
        if ({12'h000, bus.reg2AddrD} !== e) begin
            errors++; $display("FAIL dec_reg2addr: got %h expected %h", bus.reg2AddrD, e);
        end
        // Same-cycle write-through, then the stored value after the edge.
        bus.regWriteEnable = 1'b1;
        bus.writeAddress = 4'd3;
        bus.writeData = 16'hABCD;
        expQ.push_back(16'hABCD);
        #1;
        e = expQ.pop_front(); checks++;
        if (bus.reg2ContentD !== e) begin
            errors++; $display("FAIL rf_write_through: got %h expected %h", bus.reg2ContentD, e);
        end
        @(negedge clock);
        bus.regWriteEnable = 1'b0;
        expQ.push_back(16'hABCD);
        #1;
        e = expQ.pop_front(); checks++;
        if (bus.reg2ContentD !== e) begin
            errors++; $display("FAIL rf_stored_r3: got %h expected %h", bus.reg2ContentD, e);
        end
        bus.pcAsR1 = 1'b1;
        bus.pcD = 16'h0007;
        expQ.push_back(16'h0007);
        expQ.push_back(16'hABCD);
        #1;
        e = expQ.pop_front(); checks++;
        if (bus.reg1ContentD !== e) begin
            errors++; $display("FAIL pc_as_r1: got %h expected %h", bus.reg1ContentD, e);
        end
        e = expQ.pop_front(); checks++;
        if (bus.reg2ContentD !== e) begin
            errors++; $display("FAIL pc_as_r1_reg2: got %h expected %h", bus.reg2ContentD, e);
        end
        bus.pcAsR1 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        #1;
        e = expQ.pop_front(); checks++;
        if (bus.reg1ContentD !== e) begin
            errors++; $display("FAIL rf_reset_r5: got %h expected %h", bus.reg1ContentD, e);
        end
        e = expQ.pop_front(); checks++;
        if (bus.reg2ContentD !== e) begin
            errors++; $display("FAIL rf_reset_r3: got %h expected %h", bus.reg2ContentD, e);
        end
    endtask

    task automatic test_immediate();
        logic [23:0] instr [2] = '{24'h000FFE, 24'h0007FF};
        logic [15:0] imm   [2] = '{16'hFFFE, 16'h07FF};
        logic [15:0] e;
        for (int i = 0; i < 2; i++) begin
            bus.instructionD = instr[i];
            expQ.push_back(imm[i]);
            #1;
            e = expQ.pop_front(); checks++;
            if (bus.immediateD !== e) begin
                errors++; $display("FAIL imm_sext[%0d]: got %h expected %h", i, bus.immediateD, e);
            end
        end
    endtask

    task automatic run_alu_table(input string name, input aluCase_t tbl [$]);
        aluExp_t e;
        foreach (tbl[i]) begin
            bus.aluControl   = tbl[i].op;
            bus.reg1ContentE = tbl[i].a;
            bus.reg2ContentE = tbl[i].b;
            bus.fwd1Select   = tbl[i].f1;
            bus.fwd2Select   = tbl[i].f2;
            bus.data2Select  = tbl[i].d2;
            bus.immediateE   = tbl[i].imm;
            aluQ.push_back('{out: tbl[i].out, nzvc: tbl[i].nzvc});
            #1;
            e = aluQ.pop_front(); checks++;
            if (bus.aluOut !== e.out) begin
                errors++; $display("FAIL %s[%0d] aluOut: got %h expected %h", name, i, bus.aluOut, e.out);
            end
            checks++;
            if ({bus.N, bus.Z, bus.V, bus.C} !== e.nzvc) begin
                errors++; $display("FAIL %s[%0d] NZVC: got %b expected %b", name, i,
                                   {bus.N, bus.Z, bus.V, bus.C}, e.nzvc);
            end
        end
    endtask

    task automatic test_alu_arith();
        aluCase_t t [$];
        t.push_back('{3'b000, 16'h7FFF, 16'h0001, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h8000, 4'b1010});
        t.push_back('{3'b001, 16'h0005, 16'h0005, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'b0101});
        t.push_back('{3'b001, 16'h0003, 16'h0005, 2'b00, 2'b00, 1'b0, 16'h0000, 16'hFFFE, 4'b1000});
        t.push_back('{3'b000, 16'hFFFF, 16'h0001, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'b0101});
        t.push_back('{3'b001, 16'h8000, 16'h0001, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h7FFF, 4'b0011});
        run_alu_table("alu_arith", t);
    endtask

    task automatic test_forwarding();
        aluCase_t t [$];
        bus.forwardM  = 16'h0010;
        bus.forwardWB = 16'h0100;
        t.push_back('{3'b000, 16'h0001, 16'h0002, 2'b10, 2'b01, 1'b0, 16'h0000, 16'h0110, 4'b0000});
        t.push_back('{3'b000, 16'h0001, 16'h0002, 2'b00, 2'b01, 1'b1, 16'h0020, 16'h0021, 4'b0000});
        t.push_back('{3'b000, 16'h0001, 16'h0002, 2'b11, 2'b00, 1'b0, 16'h0000, 16'h0003, 4'b0000});
        t.push_back('{3'b000, 16'h0001, 16'h0002, 2'b01, 2'b11, 1'b0, 16'h0000, 16'h0102, 4'b0000});
        t.push_back('{3'b000, 16'h0001, 16'h0002, 2'b00, 2'b10, 1'b0, 16'h0000, 16'h0011, 4'b0000});
        run_alu_table("forwarding", t);
    endtask

    task automatic test_logic_shift();
        aluCase_t t [$];
        t.push_back('{3'b010, 16'hF0F0, 16'h0FF0, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h00F0, 4'b0000});
        t.push_back('{3'b011, 16'hF0F0, 16'h0FF0, 2'b00, 2'b00, 1'b0, 16'h0000, 16'hFFF0, 4'b1000});
        t.push_back('{3'b100, 16'hF0F0, 16'h0FF0, 2'b00, 2'b00, 1'b0, 16'h0000, 16'hFF00, 4'b1000});
        t.push_back('{3'b101, 16'h0001, 16'h0004, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0010, 4'b0000});
        t.push_back('{3'b101, 16'h0001, 16'h0014, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0010, 4'b0000});
        t.push_back('{3'b110, 16'h8000, 16'h000F, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0001, 4'b0000});
        t.push_back('{3'b111, 16'hFFFF, 16'h00AA, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h00AA, 4'b0000});
        t.push_back('{3'b111, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'b0100});
        run_alu_table("logic_shift", t);
    endtask

    initial begin
        bus.newPC          = '0;
        bus.takeBranch     = 1'b0;
        bus.fetchEnable    = 1'b0;
        bus.instructionD   = '0;
        bus.pcD            = '0;
        bus.pcAsR1         = 1'b0;
        bus.regWriteEnable = 1'b0;
        bus.writeAddress   = '0;
        bus.writeData      = '0;
        bus.reg1ContentE   = '0;
        bus.reg2ContentE   = '0;
        bus.immediateE     = '0;
        bus.forwardM       = '0;
        bus.forwardWB      = '0;
        bus.aluControl     = '0;
        bus.data2Select    = 1'b0;
        bus.fwd1Select     = '0;
        bus.fwd2Select     = '0;

        test_reset();
        test_pc();
        test_regfile();
        test_immediate();
        test_alu_arith();
        test_forwarding();
        test_logic_shift();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fde_datapath
`default_nettype wire
